// File: rtl/fifo_stream_ctrl.sv
// Stream flow control and address generation for a registered-read FIFO storage array.
// The write side gates the upstream stream into memory writes. The read side absorbs the one-cycle read latency in a 2-entry queue.
module fifo_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_wen,
  output logic [ASIZE-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ASIZE-1:0]      mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ASIZE:0]        count,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  drop_err
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] qbuf_q [2];
  logic                  drop_err_q;

  logic [PW-1:0] cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          issue;
  logic          tail;
  logic [2:0]    credit;

  // Handshake, credit and pointer next-state
  always_comb begin
    cnt      = wr_ptr_q - rd_ptr_q;
    full     = (cnt == PW'(DATA_DEPTH));
    pop      = (occ_q != 2'd0) && out_ready;
    push     = in_valid && !full && !flush && !rst;
    // Queue slots already promised: held entries plus the read in flight
    credit   = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    issue    = (cnt != '0) && (credit < 3'd2) && !flush && !rst;
    tail     = head_q ^ occ_q[0];
    wr_ptr_d = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d    = occ_q + 2'(inflight_q) - 2'(pop);
    head_d   = pop ? ~head_q : head_q;
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      qbuf_q[0]  <= '0;
      qbuf_q[1]  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      if (in_valid && full) drop_err_q <= 1'b1;
      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        inflight_q <= 1'b0;
        occ_q      <= 2'd0;
        head_q     <= 1'b0;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        inflight_q <= issue;
        occ_q      <= occ_d;
        head_q     <= head_d;
        if (inflight_q) qbuf_q[tail] <= mem_rdata;
      end
    end
  end

  assign in_ready    = !full;
  assign mem_wen     = push;
  assign mem_waddr   = wr_ptr_q[ASIZE-1:0];
  assign mem_wdata   = in_data;
  assign mem_ren     = issue;
  assign mem_raddr   = rd_ptr_q[ASIZE-1:0];
  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = qbuf_q[head_q];
  assign count       = cnt;
  assign almost_full = (cnt >= PW'(AF_LEVEL));
  assign empty       = (cnt == '0) && !inflight_q && (occ_q == 2'd0);
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Directed bench for fifo_stream_ctrl with a behavioural 16x8 registered-read storage array.
module tb_fifo_stream_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          wclk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, mem_wdata, mem_rdata;
  logic          mem_wen, mem_ren, almost_full, empty, drop_err;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wclk = ~wclk;

  fifo_stream_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(16), .ASIZE(AW), .AF_LEVEL(12)) dut (
    .wclk(wclk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count), .almost_full(almost_full), .empty(empty), .drop_err(drop_err)
  );

  // Storage array: synchronous write, registered read
  logic [DW-1:0] mem [16];
  always @(posedge wclk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_drop_err"}, 32'(drop_err), 32'd0);
  endtask

  // Drains with out_ready=1 until empty, bounded
  task automatic drain_until_empty(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (empty) break;
      tick();
    end
    check({tag, "_drained"}, 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rx;
    int first;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Single word latency
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    #1;
    check("lat_mem_wen", 32'(mem_wen), 32'd1);
    check("lat_mem_waddr", 32'(mem_waddr), 32'd0);
    check("lat_mem_wdata", 32'(mem_wdata), 32'h11);
    check("lat_no_early_ren", 32'(mem_ren), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("lat_mem_ren", 32'(mem_ren), 32'd1);
    check("lat_mem_raddr", 32'(mem_raddr), 32'd0);
    check("lat_count1", 32'(count), 32'd1);
    check("lat_not_empty", 32'(empty), 32'd0);
    tick(); #1;
    check("lat_valid_not_yet", 32'(out_valid), 32'd0);
    tick(); #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", 32'(out_data), 32'h11);
    tick(); #1;
    check("lat_empty_after_pop", 32'(empty), 32'd1);

    // Full-rate stream with pointer wrap
    rx = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 32); in_data = 8'(c); out_ready = 1'b1;
      #1;
      if (c < 32) check("stream_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (rx == 0) first = c;
        check("stream_data", 32'(out_data), 32'(rx));
        rx++;
      end else if (rx > 0 && rx < 32) begin
        check("stream_bubble", 32'(out_valid), 32'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("stream_rx_count", 32'(rx), 32'd32);
    check("stream_first_cycle", 32'(first), 32'd3);
    check("stream_empty", 32'(empty), 32'd1);

    // Fill to full with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(32'hA0 + i);
      #1;
      check("fill_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); #1;
    check("fill_count14", 32'(count), 32'd14);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_head", 32'(out_data), 32'hA0);
    for (int i = 16; i < 18; i++) begin
      in_valid = 1'b1; in_data = 8'(32'hA0 + i);
      #1;
      tick();
    end
    in_valid = 1'b1; in_data = 8'hFF;
    #1;
    check("full_count16", 32'(count), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_almost_full", 32'(almost_full), 32'd1);
    check("full_no_write", 32'(mem_wen), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("drop_err_set", 32'(drop_err), 32'd1);
    check("full_count_kept", 32'(count), 32'd16);
    rx = 0; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (out_valid) begin
        check("drain_data", 32'(out_data), 32'hA0 + 32'(rx));
        rx++;
      end
      tick();
    end
    check("drain_rx_count", 32'(rx), 32'd18);
    check("drain_empty", 32'(empty), 32'd1);

    // almost_full boundary with simultaneous push and issue
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_data = 8'(32'hE0 + i);
      #1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); #1;
    check("af_count11", 32'(count), 32'd11);
    check("af_low", 32'(almost_full), 32'd0);
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    check("af_push", 32'(mem_wen), 32'd1);
    check("af_issue", 32'(mem_ren), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("af_count_unchanged", 32'(count), 32'd11);
    check("af_still_low", 32'(almost_full), 32'd0);
    drain_until_empty("af");

    // Flush while a read is in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(32'hC0 + i);
      #1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); #1;
    check("fl_count3", 32'(count), 32'd3);
    out_ready = 1'b1;
    #1;
    check("fl_pop_head", 32'(out_data), 32'hC0);
    check("fl_issue", 32'(mem_ren), 32'd1);
    tick();
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    check("fl_wen_blocked", 32'(mem_wen), 32'd0);
    check("fl_ren_blocked", 32'(mem_ren), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_count0", 32'(count), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_drop_err_kept", 32'(drop_err), 32'd1);
    in_valid = 1'b1; in_data = 8'hD5; out_ready = 1'b1;
    #1;
    check("fl_waddr0", 32'(mem_waddr), 32'd0);
    tick();
    in_valid = 1'b0;
    rx = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (rx == 0) check("fl_first_after", 32'(out_data), 32'hD5);
        rx++;
      end
      tick();
    end
    check("fl_one_word", 32'(rx), 32'd1);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(32'h50 + i); out_ready = 1'b1;
      #1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_state("midrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
- Flow-control and address-generation stage that drives the team's 16x8 FIFO storage array. The array has a registered read and no internal handshaking.
- Upstream side: converts a valid/ready write stream into mem write strobes and addresses.
- Downstream side: issues reads, absorbs the 1-cycle memory read latency in a 2-entry output queue, and presents a valid/ready read stream.
- Single clock domain; sits between the packet producer and the consumer.

Parameters:
- DATA_WIDTH, 8, width of data words.
- DATA_DEPTH, 16, number of storage entries; must equal 2**ASIZE.
- ASIZE, 4, memory address width.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL.

Ports:
- wclk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  synchronous clear of all contents; error flag preserved.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_WIDTH  upstream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  head word.
- mem_wen  out  1  memory write strobe.
- mem_waddr  out  ASIZE  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ren  out  1  memory read strobe.
- mem_raddr  out  ASIZE  read address.
- mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after mem_ren.
- count  out  ASIZE+1  entries held in memory and not yet read-issued.
- almost_full  out  1  count >= AF_LEVEL.
- empty  out  1  nothing in memory, nothing in flight, output queue empty.
- drop_err  out  1  sticky: in_valid seen while in_ready=0.

Behaviour:
- Reset: rst is synchronous, active-high, clock wclk.
  - wr_ptr, rd_ptr, inflight, queue occupancy and drop_err clear to 0.
  - out_valid=0, out_data=0, count=0, almost_full=0, empty=1.
  - in_ready=1 during the first cycle after reset.
- Pointers: wr_ptr and rd_ptr are ASIZE+1 bits and wrap naturally.
  - count = wr_ptr - rd_ptr, modulo 2**(ASIZE+1).
  - full = (count == DATA_DEPTH).
- Write path:
  - in_ready = !full.
  - push = in_valid && in_ready.
  - mem_wen = push, mem_waddr = wr_ptr[ASIZE-1:0], mem_wdata = in_data. All three are combinational.
  - wr_ptr increments on push.
- Read issue:
  - pop = out_valid && out_ready.
  - occ is the queue occupancy, 0..2. inflight is a 1-bit register, set for the cycle after an issue.
  - issue = (count != 0) && (occ + inflight - pop < 2).
  - mem_ren = issue, mem_raddr = rd_ptr[ASIZE-1:0].
  - rd_ptr increments on issue; inflight <= issue.
- Capture: when inflight=1, mem_rdata is written into the queue tail at that clock edge.
  - A pop in the same cycle is allowed.
  - The queue never overflows, by the credit rule.
- Output queue:
  - 2-entry FIFO; out_data = head entry; out_valid = (occ != 0).
  - Head is stable while out_valid && !out_ready.
- Latency: a word pushed at edge E into an empty block follows this sequence:
  - Read is issued in the cycle after E.
  - Captured at E+2.
  - out_valid=1 in the cycle after E+2.
  - Sustained throughput is 1 word/cycle in both directions.
- Simultaneous push and issue: both pointers move; count is unchanged.
  - Issue only uses entries already counted at the previous edge, so there is no same-address read/write hazard.
- Full: in_ready=0 and no write occurs.
  - in_valid=1 in that cycle sets drop_err.
  - drop_err stays set until rst; flush does not clear it.
- Empty and almost_full are combinational:
  - empty = (count==0) && !inflight && (occ==0).
  - almost_full = (count >= AF_LEVEL).
- Flush (rst has priority):
  - Pointers, inflight and occ clear at the edge, and in-flight read data is discarded.
  - push and issue in the flush cycle are ignored: mem_wen and mem_ren are forced to 0.
- Reset mid-operation behaves as flush and also clears drop_err.

Test Plan:
- Reset, then push 0x11 at edge E with out_ready=1 -> mem_wen=1 and mem_waddr=0 in the push cycle; mem_ren=1 and mem_raddr=0 in the cycle after E; out_valid=1 with out_data=0x11 in the cycle after E+2; empty=1 after the pop.
- Stream 0x00..0x1F with in_valid=1 and out_ready=1 throughout -> no bubbles after the 3-cycle fill; outputs appear in order; pointers wrap 31->0 with no loss.
- out_ready=0 and push 16 words -> queue holds 2 and count=14; push 2 more -> count=16, in_ready=0, almost_full=1. A 19th in_valid sets drop_err=1. Then out_ready=1 -> 18 words drained in order, 0 lost.
- count=AF_LEVEL-1 with a push and an issue in the same cycle -> count unchanged and almost_full stays 0.
- Flush pulsed in the cycle inflight=1, with 5 words queued -> next cycle count=0, out_valid=0, empty=1; the captured word never appears; drop_err is kept.
- rst asserted mid-stream -> all outputs return to their reset values on the next edge; drop_err=0.
